// File: rtl/alu_pkg.sv
// Shared opcode constants and requester ID type for the ALU and its
// two-requester arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_EQ   = 4'b1000;
  localparam logic [3:0] ALU_LT   = 4'b1001;
  localparam logic [3:0] ALU_GE   = 4'b1010;
  localparam logic [3:0] ALU_NE   = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_TRUE = 4'b1111;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU. Compare results are zero-extended 0/1, and
// opcodes 1101/1110 return 0 as legal no-result operations.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [OPCODE_LENGTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  output logic [DATA_WIDTH-1:0]    result
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic [SHAMT_W-1:0] shamt_s;
  assign shamt_s = b[SHAMT_W-1:0];

  // Operation decode; both LT encodings compare unsigned
  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt_s;
      ALU_SRL:  result = a >> shamt_s;
      ALU_SUB:  result = a - b;
      ALU_SRA:  result = $signed(a) >>> shamt_s;
      ALU_EQ:   result = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      ALU_LT:   result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      ALU_GE:   result = {{(DATA_WIDTH-1){1'b0}}, (a >= b)};
      ALU_NE:   result = {{(DATA_WIDTH-1){1'b0}}, (a != b)};
      ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      ALU_TRUE: result = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters through
// an issue register (S1) and an ID-tagged output register (S2).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output req_id_t                  rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_result
);

  logic                     s1_valid_r;
  logic [DATA_WIDTH-1:0]    s1_a_r;
  logic [DATA_WIDTH-1:0]    s1_b_r;
  logic [OPCODE_LENGTH-1:0] s1_op_r;
  req_id_t                  s1_id_r;
  req_id_t                  last_grant_r;

  logic                  s2_free_s;
  logic                  s1_free_s;
  logic                  grant_ok_s;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  handshake_s;
  logic [DATA_WIDTH-1:0] alu_result_s;

  assign s2_free_s  = !rsp_valid || rsp_ready;
  assign s1_free_s  = !s1_valid_r || s2_free_s;
  assign grant_ok_s = s1_free_s && !flush && !reset;

  // On a tie the requester that did not win last time is granted
  assign grant0_s = grant_ok_s && req0_valid && (!req1_valid || (last_grant_r == REQ1));
  assign grant1_s = grant_ok_s && req1_valid && (!req0_valid || (last_grant_r == REQ0));

  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;
  assign handshake_s = grant0_s || grant1_s;

  alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_alu (
    .op     (s1_op_r),
    .a      (s1_a_r),
    .b      (s1_b_r),
    .result (alu_result_s)
  );

  // Issue register and round-robin pointer; flush leaves data and pointer intact
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r   <= 1'b0;
      s1_a_r       <= '0;
      s1_b_r       <= '0;
      s1_op_r      <= '0;
      s1_id_r      <= REQ0;
      last_grant_r <= REQ1;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (handshake_s) begin
      s1_valid_r   <= 1'b1;
      s1_a_r       <= grant1_s ? req1_a  : req0_a;
      s1_b_r       <= grant1_s ? req1_b  : req0_b;
      s1_op_r      <= grant1_s ? req1_op : req0_op;
      s1_id_r      <= grant1_s ? REQ1 : REQ0;
      last_grant_r <= grant1_s ? REQ1 : REQ0;
    end else if (s1_valid_r && s2_free_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Output register; S1 drains into it on the same edge S2 is consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= REQ0;
      rsp_result <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (s1_valid_r && s2_free_s) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= s1_id_r;
      rsp_result <= alu_result_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between two requesters, for example the integer-execute path and the branch-compare path, through valid/ready handshakes. Round-robin arbitration picks one request per cycle. The granted operands go into an issue register, and the ALU result goes into an output register tagged with the requester ID. The block is a 2-stage pipeline with full backpressure and a synchronous flush for pipeline squash.

## Interface
- `DATA_WIDTH`, 32, operand and result width.
- `OPCODE_LENGTH`, 4, ALU operation code width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous squash of both pipeline stages.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when both valid and ready are high.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_WIDTH  operands.
- `req0_op` / `req1_op`  in  OPCODE_LENGTH  ALU operation.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  ID of the requester that issued the result.
- `rsp_result`  out  DATA_WIDTH  ALU result.

## Operation
- **Stage S1 (issue register):** holds `s1_valid`, `a`, `b`, `op`, `id`. The `alu` reads S1 combinationally.
- **Stage S2 (output register):** holds `rsp_valid`, `rsp_id`, `rsp_result`.
- **Advance conditions:**
  - `s2_free = !rsp_valid || rsp_ready`.
  - `s1_free = !s1_valid || s2_free`.
- **Grant:** only when `s1_free && !flush && !reset`.
  - One valid requester: that requester is granted.
  - Both valid: the requester other than `last_grant` is granted.
  - The granted requester's ready goes high. The other ready stays 0.
  - Ready may depend combinationally on the valids. Requesters must not make valid depend on ready.
- **`last_grant`:** updates only on an accepted handshake.
- **S1 load:** on a handshake S1 loads the operands and `s1_valid=1`. Otherwise, if S1 advances into S2, `s1_valid=0`.
- **S2 load:** when `s1_valid && s2_free`, S2 takes the ALU output and `s1.id`, and `rsp_valid=1`. Else, if `rsp_ready`, `rsp_valid=0`.
- **ALU semantics (unchanged inside `alu`):**
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA.
  - 1000 EQ, 1001 LT unsigned, 1010 GE unsigned, 1011 NE, 1100 LT unsigned.
  - 1111 gives 1.
  - 1101 and 1110 give 0. They are legal requests, not errors.
  - Arithmetic wraps modulo 2^DATA_WIDTH.
- **flush:** clears `s1_valid` and `rsp_valid` and forces both readys to 0 that cycle. `last_grant` and data registers are left unchanged. A request presented during flush is not accepted and must be held.
- **Reset values:** `s1_valid=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `last_grant=1` (requester 0 wins the first tie), `req0_ready=0`, `req1_ready=0`.
- **Priority:** `reset` beats `flush`, and `flush` beats a handshake.

## Timing
- **Latency:** handshake at edge N gives `rsp_valid` high after edge N+1, so results come 2 cycles after request presentation.
- **Throughput:** 1 result per cycle with `rsp_ready` held high, tie alternation 0,1,0,1.
- **Backpressure with `rsp_ready=0`:**
  - S2 holds, and `rsp_id`/`rsp_result` stay stable while `rsp_valid=1`.
  - S1 fills on the next grant, then both readys drop.
  - On release, S1 drains into S2 on the same edge that S2 is consumed. There is no bubble.
- **Starvation:** at most one grant to the other requester between two grants to a continuously valid requester.
- **Reset or flush mid-operation:** in-flight results are discarded with no response. Issue resumes the cycle after deassertion.

## Structure
- **Package `alu_pkg`:**
  - ALU opcode constants: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_XOR`, `ALU_SLL`, `ALU_SRL`, `ALU_SUB`, `ALU_SRA`, `ALU_EQ`, `ALU_LT`, `ALU_GE`, `ALU_NE`, `ALU_SLT`, `ALU_TRUE`.
  - `req_id_t` (1 bit).
- **Sub-module:** exactly one instance of the existing `alu` (`DATA_WIDTH`, `OPCODE_LENGTH` passed through), fed from S1.
- **This block contains:** arbitration, S1/S2 registers, `last_grant`.

## Test plan
- **Single request:** req0 ADD, a=5, b=7, `rsp_ready=1` -> `rsp_valid` 2 cycles later, `rsp_id=0`, `rsp_result=12`.
- **Tie and alternation:** both valid for 4 cycles, req0 SUB 10-3, req1 EQ 4==4 -> grants 0,1,0,1; results 7(id0), 1(id1), 7, 1 on consecutive cycles.
- **Backpressure:** `rsp_ready=0` for 5 cycles during streaming -> `rsp_result` stable, at most 2 requests accepted, readys 0 afterwards. On release there is no lost or duplicated result and order is preserved.
- **Flush:** assert `flush` with S1 and S2 both full -> `rsp_valid=0` next cycle, no response for the squashed IDs. A held req1 XOR 0xF0^0x0F gives 0xFF afterwards.
- **Edge ops:**
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - ADD 0xFFFFFFFF+1 -> 0.
  - op 1101 -> 0.
  - op 1111 -> 1.
- **Reset mid-stream:** reset with both stages full -> all outputs at reset values the next cycle. The first tie after reset is granted to req0.
